// File: rtl/cpu_pkg.sv
// Shared definitions for the MCS8 interrupt controller: CPU T-state codes,
// the RST opcode template and the acknowledge FSM encoding.
package cpu_pkg;

  localparam logic [2:0] ST_T1   = 3'b010;
  localparam logic [2:0] ST_T2   = 3'b100;
  localparam logic [2:0] ST_T3   = 3'b001;
  localparam logic [2:0] ST_T4   = 3'b111;
  localparam logic [2:0] ST_T5   = 3'b101;
  localparam logic [2:0] ST_T1I  = 3'b110;
  localparam logic [2:0] ST_STOP = 3'b011;
  localparam logic [2:0] ST_WAIT = 3'b000;

  // RST n opcode is 00_nnn_101; the vector is ORed into bits [5:3]
  localparam logic [7:0] RST_OPCODE = 8'b00_000_101;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_REQ  = 2'd1,
    FSM_ACK  = 2'd2,
    FSM_JAM  = 2'd3
  } intcState_e;

  function automatic logic [7:0] lowestBit(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

endpackage

// File: rtl/cpu_intc_prio.sv
// Priority resolver: eligible requests after mask and in-service gating,
// and the lowest-numbered (highest-priority) eligible vector.
module cpu_intc_prio
  import cpu_pkg::*;
(
  input  logic [7:0] pend,
  input  logic [7:0] mask,
  input  logic [7:0] isr,
  input  logic       nest,
  output logic       eligAny,
  output logic [2:0] vec
);

  logic [7:0] gate;
  logic [7:0] elig;
  logic       found;

  always_comb begin
    gate  = '1;
    vec   = '0;
    found = 1'b0;
    // Nesting admits only bits strictly above the highest-priority ISR bit
    if (isr != '0)
      gate = nest ? (lowestBit(isr) - 8'd1) : '0;
    elig    = pend & ~mask & gate;
    eligAny = |elig;
    for (int unsigned i = 0; i < 8; i++) begin
      if (elig[i] && !found) begin
        vec   = 3'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_intc.sv
// 8-input interrupt controller for the MCS8 core: raises INT, and on the
// T1I acknowledge cycle jams an RST opcode onto the data bus during T3.
module cpu_intc
  import cpu_pkg::*;
#(
  parameter bit         EDGE     = 1'b1,
  parameter bit         NEST     = 1'b1,
  parameter logic [2:0] SPUR_VEC = 3'd7
) (
  input  logic       CLK_I,
  input  logic       nRST_I,
  input  logic [7:0] IRQ_I,
  input  logic [2:0] STATE_I,
  input  logic       MASK_WE_I,
  input  logic [7:0] MASK_I,
  input  logic       EOI_I,
  output logic       INT_O,
  output logic [7:0] DAT_O,
  output logic       DAT_OE_O,
  output logic [7:0] PEND_O,
  output logic [7:0] ISR_O
);

  intcState_e state;
  logic [7:0] irqPrev;
  logic [7:0] pend;
  logic [7:0] mask;
  logic [7:0] isr;
  logic [2:0] vecQ;
  logic       intQ;

  logic       eligAny;
  logic [2:0] vec;
  logic       ack;
  logic [7:0] irqSet;
  logic [7:0] ackSet;
  logic [7:0] pendNext;
  logic [7:0] isrNext;

  cpu_intc_prio uPrio (
    .pend    (pend),
    .mask    (mask),
    .isr     (isr),
    .nest    (NEST),
    .eligAny (eligAny),
    .vec     (vec)
  );

  always_comb begin
    irqSet   = EDGE ? (IRQ_I & ~irqPrev) : IRQ_I;
    ack      = (state == FSM_REQ) && (STATE_I == ST_T1I);
    ackSet   = (ack && eligAny) ? (8'd1 << vec) : '0;
    // New request wins over the acknowledge clear of the same bit
    pendNext = (pend & ~ackSet) | irqSet;
    // EOI retires the old lowest in-service bit before the new one is set
    isrNext  = (EOI_I ? (isr & ~lowestBit(isr)) : isr) | ackSet;
  end

  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      state   <= FSM_IDLE;
      irqPrev <= '0;
      pend    <= '0;
      mask    <= '1;
      isr     <= '0;
      vecQ    <= '0;
      intQ    <= 1'b0;
    end else begin
      irqPrev <= IRQ_I;
      pend    <= pendNext;
      isr     <= isrNext;
      if (MASK_WE_I)
        mask <= MASK_I;
      case (state)
        FSM_IDLE:
          if (eligAny) begin
            state <= FSM_REQ;
            intQ  <= 1'b1;
          end
        FSM_REQ:
          if (ack) begin
            state <= FSM_ACK;
            intQ  <= 1'b0;
            vecQ  <= eligAny ? vec : SPUR_VEC;
          end
        FSM_ACK:
          if (STATE_I == ST_T3)
            state <= FSM_JAM;
        FSM_JAM:
          if (STATE_I != ST_T3)
            state <= FSM_IDLE;
      endcase
    end
  end

  assign DAT_OE_O = ((state == FSM_ACK) || (state == FSM_JAM)) && (STATE_I == ST_T3);
  assign DAT_O    = DAT_OE_O ? (RST_OPCODE | {2'b00, vecQ, 3'b000}) : '0;
  assign INT_O    = intQ;
  assign PEND_O   = pend;
  assign ISR_O    = isr;

endmodule

// File: tb/tb_cpu_intc.sv
// Randomized and directed bench for cpu_intc, two instances (edge/nested and
// level/non-nested) checked every cycle against a behavioural model.
module tb_cpu_intc;

  localparam logic [2:0] TS_T1I  = 3'b110;
  localparam logic [2:0] TS_T2   = 3'b100;
  localparam logic [2:0] TS_T3   = 3'b001;
  localparam logic [2:0] TS_T4   = 3'b111;
  localparam logic [2:0] TS_WAIT = 3'b000;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_ACK  = 2;
  localparam int P_JAM  = 3;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] irq;
  logic [2:0] st;
  logic       mwe;
  logic [7:0] msk;
  logic       eoi;

  logic       intA, intB, oeA, oeB;
  logic [7:0] datA, datB, pendA, pendB, isrA, isrB;

  always #5 clk = ~clk;

  cpu_intc #(.EDGE(1'b1), .NEST(1'b1), .SPUR_VEC(3'd7)) dutA (
    .CLK_I(clk), .nRST_I(rstN), .IRQ_I(irq), .STATE_I(st),
    .MASK_WE_I(mwe), .MASK_I(msk), .EOI_I(eoi),
    .INT_O(intA), .DAT_O(datA), .DAT_OE_O(oeA), .PEND_O(pendA), .ISR_O(isrA)
  );

  cpu_intc #(.EDGE(1'b0), .NEST(1'b0), .SPUR_VEC(3'd7)) dutB (
    .CLK_I(clk), .nRST_I(rstN), .IRQ_I(irq), .STATE_I(st),
    .MASK_WE_I(mwe), .MASK_I(msk), .EOI_I(eoi),
    .INT_O(intB), .DAT_O(datB), .DAT_OE_O(oeB), .PEND_O(pendB), .ISR_O(isrB)
  );

  typedef struct packed {
    logic [7:0] pend;
    logic [7:0] isr;
    logic [7:0] mask;
    logic [7:0] prev;
    int         phase;
    int         vec;
    logic       intr;
  } mdl_t;

  mdl_t       mdl [2];
  bit         edgeP [2] = '{1'b1, 1'b0};
  bit         nestP [2] = '{1'b1, 1'b0};
  logic       sOe [2];
  logic [7:0] sDat [2];
  int         nCmp = 0;
  int         nBad = 0;

  task automatic checkEq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pickVec(input mdl_t s, input bit nest);
    int low;
    low = 8;
    for (int i = 7; i >= 0; i--) if (s.isr[i]) low = i;
    for (int i = 0; i < 8; i++)
      if (s.pend[i] && !s.mask[i] && (nest ? (i < low) : (low == 8))) return i;
    return -1;
  endfunction

  function automatic mdl_t stepMdl(input mdl_t s, input bit edg, input bit nest);
    mdl_t n;
    int   v;
    n = s;
    v = pickVec(s, nest);
    case (s.phase)
      P_IDLE: if (v >= 0) begin n.phase = P_REQ; n.intr = 1'b1; end
      P_REQ:  if (st == TS_T1I) begin
                n.intr  = 1'b0;
                n.phase = P_ACK;
                n.vec   = (v >= 0) ? v : 7;
              end
      P_ACK:  if (st == TS_T3) n.phase = P_JAM;
      default: if (st != TS_T3) n.phase = P_IDLE;
    endcase
    if (eoi)
      for (int i = 0; i < 8; i++) if (s.isr[i]) begin n.isr[i] = 1'b0; break; end
    if (s.phase == P_REQ && st == TS_T1I && v >= 0) begin
      n.isr[v]  = 1'b1;
      n.pend[v] = 1'b0;
    end
    for (int i = 0; i < 8; i++)
      if (irq[i] && (!edg || !s.prev[i])) n.pend[i] = 1'b1;
    if (mwe) n.mask = msk;
    n.prev = irq;
    return n;
  endfunction

  task automatic mdlReset();
    for (int k = 0; k < 2; k++) begin
      mdl[k].pend  = 8'h00;
      mdl[k].isr   = 8'h00;
      mdl[k].mask  = 8'hFF;
      mdl[k].prev  = 8'h00;
      mdl[k].phase = P_IDLE;
      mdl[k].vec   = 0;
      mdl[k].intr  = 1'b0;
    end
  endtask

  task automatic compareOuts();
    for (int k = 0; k < 2; k++) begin
      string      p;
      logic       ii, oo, expOe;
      logic [7:0] dd, pp, ss, expDat;
      p  = (k == 0) ? "A" : "B";
      ii = (k == 0) ? intA : intB;
      oo = (k == 0) ? oeA : oeB;
      dd = (k == 0) ? datA : datB;
      pp = (k == 0) ? pendA : pendB;
      ss = (k == 0) ? isrA : isrB;
      expOe  = (mdl[k].phase == P_ACK || mdl[k].phase == P_JAM) && (st == TS_T3);
      expDat = expOe ? 8'(5 + 8 * mdl[k].vec) : 8'h00;
      checkEq({p, ".int"},  8'(ii), 8'(mdl[k].intr));
      checkEq({p, ".oe"},   8'(oo), 8'(expOe));
      checkEq({p, ".dat"},  dd, expDat);
      checkEq({p, ".pend"}, pp, mdl[k].pend);
      checkEq({p, ".isr"},  ss, mdl[k].isr);
      sOe[k]  = oo;
      sDat[k] = dd;
    end
  endtask

  task automatic tick(input logic [7:0] i, input logic [2:0] s, input logic w,
                      input logic [7:0] m, input logic e);
    irq = i; st = s; mwe = w; msk = m; eoi = e;
    @(negedge clk);
    compareOuts();
    @(posedge clk);
    for (int k = 0; k < 2; k++) mdl[k] = stepMdl(mdl[k], edgeP[k], nestP[k]);
    #1;
  endtask

  task automatic cyc(input logic [7:0] i, input logic [2:0] s);
    tick(i, s, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic eoiPulse();
    tick(8'h00, TS_WAIT, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    rstN = 1'b0; irq = '0; st = TS_WAIT; mwe = 1'b0; msk = '0; eoi = 1'b0;
    mdlReset();
    repeat (2) @(posedge clk);
    #1;
    checkEq("rst.int",  8'(intA), 8'h00);
    checkEq("rst.oe",   8'(oeA),  8'h00);
    checkEq("rst.dat",  datA,     8'h00);
    checkEq("rst.pend", pendA,    8'h00);
    checkEq("rst.isr",  isrA,     8'h00);
    rstN = 1'b1;

    // single request on line 3, full acknowledge
    tick(8'h00, TS_WAIT, 1'b1, 8'h00, 1'b0);
    cyc(8'h08, TS_WAIT);
    checkEq("lat.early", 8'(intA), 8'h00);
    cyc(8'h00, TS_WAIT);
    checkEq("lat.int", 8'(intA), 8'h01);
    cyc(8'h00, TS_T1I);
    cyc(8'h00, TS_T2);
    checkEq("t2.oe", 8'(sOe[0]), 8'h00);
    cyc(8'h00, TS_T3);
    checkEq("t3.oe", 8'(sOe[0]), 8'h01);
    checkEq("t3.dat", sDat[0], 8'h1D);
    checkEq("ack3.isr", isrA, 8'h08);
    checkEq("ack3.pend", pendA, 8'h00);
    cyc(8'h00, TS_T4);
    eoiPulse();
    checkEq("eoi3.isr", isrA, 8'h00);

    // line 5 then line 1 before acknowledge: 1 wins, 5 stays pending
    cyc(8'h20, TS_WAIT);
    cyc(8'h00, TS_WAIT);
    cyc(8'h02, TS_WAIT);
    cyc(8'h00, TS_WAIT);
    cyc(8'h00, TS_T1I);
    cyc(8'h00, TS_T3);
    checkEq("prio.dat", sDat[0], 8'h0D);
    cyc(8'h00, TS_T4);
    checkEq("prio.pend", pendA, 8'h20);
    eoiPulse();
    cyc(8'h00, TS_WAIT);
    cyc(8'h00, TS_T1I);
    cyc(8'h00, TS_T3);
    checkEq("prio2.dat", sDat[0], 8'h2D);
    cyc(8'h00, TS_T4);
    eoiPulse();

    // nesting: ISR=04 blocks line 6 but admits line 0
    cyc(8'h04, TS_WAIT);
    cyc(8'h00, TS_WAIT);
    cyc(8'h00, TS_T1I);
    cyc(8'h00, TS_T3);
    cyc(8'h00, TS_T4);
    checkEq("nest.isr4", isrA, 8'h04);
    cyc(8'h40, TS_WAIT);
    cyc(8'h00, TS_WAIT);
    cyc(8'h00, TS_WAIT);
    checkEq("nest.blk", 8'(intA), 8'h00);
    cyc(8'h01, TS_WAIT);
    cyc(8'h00, TS_WAIT);
    checkEq("nest.int", 8'(intA), 8'h01);
    cyc(8'h00, TS_T1I);
    cyc(8'h00, TS_T3);
    checkEq("nest.dat", sDat[0], 8'h05);
    cyc(8'h00, TS_T4);
    checkEq("nest.isr5", isrA, 8'h05);
    eoiPulse();
    eoiPulse();
    checkEq("nest.isr0", isrA, 8'h00);
    cyc(8'h00, TS_WAIT);
    cyc(8'h00, TS_T1I);
    cyc(8'h00, TS_T3);
    checkEq("nest.dat6", sDat[0], 8'h35);
    cyc(8'h00, TS_T4);
    eoiPulse();

    // mask everything while requesting: spurious vector, ISR untouched
    cyc(8'h10, TS_WAIT);
    cyc(8'h00, TS_WAIT);
    tick(8'h00, TS_WAIT, 1'b1, 8'hFF, 1'b0);
    cyc(8'h00, TS_T1I);
    checkEq("spur.int", 8'(intA), 8'h00);
    cyc(8'h00, TS_T3);
    checkEq("spur.dat", sDat[0], 8'h3D);
    cyc(8'h00, TS_T4);
    checkEq("spur.isr", isrA, 8'h00);
    checkEq("spur.pend", pendA, 8'h10);
    tick(8'h00, TS_WAIT, 1'b1, 8'h00, 1'b0);
    cyc(8'h00, TS_WAIT);
    cyc(8'h00, TS_T1I);
    cyc(8'h00, TS_T3);
    checkEq("unmask.dat", sDat[0], 8'h25);
    cyc(8'h00, TS_T4);
    eoiPulse();

    // stretched acknowledge, then asynchronous reset during T3
    cyc(8'h08, TS_WAIT);
    cyc(8'h00, TS_WAIT);
    cyc(8'h00, TS_T1I);
    cyc(8'h00, TS_T2);
    checkEq("wait.t2", 8'(sOe[0]), 8'h00);
    for (int n = 0; n < 3; n++) begin
      cyc(8'h00, TS_WAIT);
      checkEq("wait.oe", 8'(sOe[0]), 8'h00);
    end
    st = TS_T3;
    #2;
    checkEq("rstT3.pre", 8'(oeA), 8'h01);
    checkEq("rstT3.dat", datA, 8'h1D);
    rstN = 1'b0;
    #1;
    checkEq("rstT3.oe",  8'(oeA), 8'h00);
    checkEq("rstT3.int", 8'(intA), 8'h00);
    checkEq("rstT3.isr", isrA, 8'h00);
    checkEq("rstT3.dato", datA, 8'h00);
    mdlReset();
    @(posedge clk);
    #1;
    st = TS_WAIT;
    rstN = 1'b1;

    // level-triggered instance: held request re-pends, no INT until EOI
    tick(8'h00, TS_WAIT, 1'b1, 8'h00, 1'b0);
    cyc(8'h04, TS_WAIT);
    cyc(8'h04, TS_WAIT);
    cyc(8'h04, TS_T1I);
    checkEq("lvl.pend", pendB, 8'h04);
    checkEq("lvl.isr", isrB, 8'h04);
    cyc(8'h04, TS_T3);
    cyc(8'h04, TS_T4);
    for (int n = 0; n < 3; n++) begin
      cyc(8'h04, TS_WAIT);
      checkEq("lvl.noint", 8'(intB), 8'h00);
    end
    tick(8'h04, TS_WAIT, 1'b0, 8'h00, 1'b1);
    cyc(8'h04, TS_WAIT);
    checkEq("lvl.int", 8'(intB), 8'h01);
    cyc(8'h00, TS_T1I);
    cyc(8'h00, TS_T3);
    cyc(8'h00, TS_T4);
    eoiPulse();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] ri, rm;
      logic [2:0] rs;
      logic       rw, re;
      ri = 8'($urandom & $urandom & $urandom);
      rs = 3'($urandom_range(0, 7));
      rw = ($urandom_range(0, 15) == 0);
      rm = 8'($urandom);
      re = ($urandom_range(0, 7) == 0);
      tick(ri, rs, rw, rm, re);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
